// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if: request/pattern inputs and grant/display outputs of the display arbiter.
interface seg_display_arbiter_if #(parameter int NREQ = 4);
    logic [NREQ-1:0]      req;
    logic [NREQ*8-1:0]    an_src;
    logic [NREQ*56-1:0]   seg_src;
    logic [NREQ-1:0]      grant;
    logic [2:0]           owner;
    logic                 busy;
    logic [7:0]           an_out;
    logic [55:0]          seg_out;
    modport master(output req, an_src, seg_src, input grant, owner, busy, an_out, seg_out);
    modport slave(input req, an_src, seg_src, output grant, owner, busy, an_out, seg_out);
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of the shared 8-digit seven-segment driver with minimum hold.
// Optional SEG_URGENT_PREEMPT_EN makes source 0 urgent (wins in idle, preempts other owners).
module seg_display_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int HOLD_W      = $clog2(HOLD_CYCLES + 1)
) (
    input logic                  clock,
    input logic                  reset,
    seg_display_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
    state_t            r_state;
    logic [NREQ-1:0]   r_grant;
    logic [2:0]        r_owner;
    logic [2:0]        r_last;
    logic              r_busy;
    logic [7:0]        r_an;
    logic [55:0]       r_seg;
    logic [HOLD_W-1:0] r_cnt;
    logic [2:0]        w_win;
    logic              w_found;
    logic              w_own_req;
    logic              w_others;
    logic              w_hold_done;
    logic              w_preempt;
    logic              w_leave;
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (int'(r_last) + k) % NREQ;
            if (!w_found && bus.req[j]) begin
                w_found = 1'b1;
                w_win   = 3'(j);
            end
        end
`ifdef SEG_URGENT_PREEMPT_EN
        if (bus.req[0]) w_win = '0;
`endif
    end
    // In OWN, r_grant is the owner's one-hot, so it masks the owner's own request.
    assign w_own_req   = |(bus.req & r_grant);
    assign w_others    = |(bus.req & ~r_grant);
    assign w_hold_done = r_cnt == HOLD_W'(HOLD_CYCLES);
`ifdef SEG_URGENT_PREEMPT_EN
    assign w_preempt   = bus.req[0] && !r_grant[0];
`else
    assign w_preempt   = 1'b0;
`endif
    assign w_leave     = !w_own_req || (w_others && w_hold_done) || w_preempt;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_last  <= 3'(NREQ - 1);
            r_busy  <= 1'b0;
            r_an    <= '0;
            r_seg   <= '0;
            r_cnt   <= '0;
        end else if (r_state == OWN) begin
            if (w_leave) begin
                r_state <= GAP;
                r_grant <= '0;
                r_busy  <= 1'b0;
                r_an    <= '0;
                r_seg   <= '0;
                r_last  <= r_owner;
            end else begin
                r_an  <= bus.an_src[int'(r_owner) * 8 +: 8];
                r_seg <= bus.seg_src[int'(r_owner) * 56 +: 56];
                r_cnt <= w_hold_done ? r_cnt : r_cnt + HOLD_W'(1);
            end
        end else if (|bus.req) begin
            r_state <= OWN;
            r_grant <= NREQ'(1) << w_win;
            r_owner <= w_win;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= IDLE;
        end
    end
    assign bus.grant   = r_grant;
    assign bus.owner   = r_owner;
    assign bus.busy    = r_busy;
    assign bus.an_out  = r_an;
    assign bus.seg_out = r_seg;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: scoreboard bench for seg_display_arbiter (NREQ=4, HOLD_CYCLES=4).
module tb_seg_display_arbiter;
    localparam int NREQ = 4;
    localparam int HOLD = 4;
    typedef struct {
        logic [3:0]  g;
        logic [2:0]  o;
        logic        b;
        logic [7:0]  a;
        logic [55:0] s;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   m_own = -1;
    int   m_last = NREQ - 1;
    int   m_age = 0;
    logic [7:0]  e_an = '0;
    logic [55:0] e_seg = '0;
    seg_display_arbiter_if #(.NREQ(NREQ)) bus ();
    seg_display_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );
    always #5 clock = ~clock;
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
        end
    endtask
    function automatic int pick(input logic [3:0] r);
        int order[$];
`ifdef SEG_URGENT_PREEMPT_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NREQ; k++) order.push_back((m_last + k) % NREQ);
        foreach (order[i]) if (r[order[i]]) return order[i];
        return -1;
    endfunction
    // Model applies the arbitration rules to the inputs seen at the coming rising edge.
    task automatic model_step(input logic [3:0] r);
        exp_t e;
        if (m_own >= 0) begin
            bit others = (r & ~(4'(1) << m_own)) != 0;
            bit leave = !r[m_own] || (others && m_age >= HOLD);
`ifdef SEG_URGENT_PREEMPT_EN
            leave = leave || (r[0] && m_own != 0);
`endif
            if (leave) begin
                m_last = m_own;
                m_own  = -1;
                e_an   = '0;
                e_seg  = '0;
            end else begin
                e_an  = bus.an_src[m_own * 8 +: 8];
                e_seg = bus.seg_src[m_own * 56 +: 56];
                if (m_age < HOLD) m_age++;
            end
        end else if (r != 0) begin
            m_own = pick(r);
            m_age = 0;
        end
        e.g = m_own >= 0 ? 4'(1) << m_own : 4'b0;
        e.o = m_own >= 0 ? 3'(m_own) : 3'b0;
        e.b = m_own >= 0;
        e.a = e_an;
        e.s = e_seg;
        q.push_back(e);
    endtask
    task automatic cyc(input logic [3:0] r);
        @(negedge clock);
        bus.req = r;
        bus.an_src = $urandom;
        for (int i = 0; i < 7; i++) bus.seg_src[i * 32 +: 32] = $urandom;
        model_step(r);
    endtask
    task automatic hold_req(input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) cyc(r);
    endtask
    task automatic check_zero(input string n);
        chk({n, "_grant"}, 64'(bus.grant), 64'h0);
        chk({n, "_busy"}, 64'(bus.busy), 64'h0);
        chk({n, "_owner"}, 64'(bus.owner), 64'h0);
        chk({n, "_an"}, 64'(bus.an_out), 64'h0);
        chk({n, "_seg"}, 64'(bus.seg_out), 64'h0);
    endtask
    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        m_own = -1;
        m_last = NREQ - 1;
        m_age = 0;
        e_an = '0;
        e_seg = '0;
        bus.req = '0;
        @(negedge clock);
        reset = 1'b1;
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("grant", 64'(bus.grant), 64'(e.g));
                chk("busy", 64'(bus.busy), 64'(e.b));
                if (e.b) chk("owner", 64'(bus.owner), 64'(e.o));
                chk("an_out", 64'(bus.an_out), 64'(e.a));
                chk("seg_out", 64'(bus.seg_out), 64'(e.s));
            end
        end
    end
    initial begin : watchdog
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
    initial begin : stim
        logic [3:0] r;
        bus.req = '0;
        bus.an_src = '0;
        bus.seg_src = '0;
        #1 check_zero("reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        hold_req(4'b0101, 14);
        hold_req(4'b0000, 3);
        hold_req(4'b0010, 4);
        hold_req(4'b0000, 2);
        hold_req(4'b0010, 100);
        hold_req(4'b0000, 2);
        hold_req(4'b0100, 2);
        cyc(4'b1000);
        hold_req(4'b1000, 5);
        do_reset();
        hold_req(4'b1001, 12);
        hold_req(4'b0000, 2);
        hold_req(4'b0100, 2);
        hold_req(4'b0101, 10);
        hold_req(4'b0000, 2);
        r = '0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < NREQ; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
            cyc(r);
        end
        do_reset();
        for (int i = 0; i < 100; i++) cyc(4'($urandom));
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 64'(q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the single 8-digit seven-segment driver (8-bit anode enable, 56-bit segment bus of 8 x 7-bit digits) between NREQ display sources, e.g. squash score, tennis score, banner, debug.
- Round-robin arbitration with a minimum hold time, so a granted source stays readable before the display switches.
- Registered outputs feed the seven-segment driver's anode/segment inputs directly; sources see a one-hot grant.

Parameters:
- NREQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 50000000, minimum clock cycles a grant is held while another requester waits (>=2).
- HOLD_W, $clog2(HOLD_CYCLES+1), hold counter width (derived; not overridden).

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low
- req  input  NREQ  level request per source; bit i = source i
- an_src  input  NREQ*8  anode enables; source i at [8i+7:8i]
- seg_src  input  NREQ*56  segment patterns; source i at [56i+55:56i]
- grant  output  NREQ  one-hot current owner, 0 when none
- owner  output  3  index of current owner, valid when busy=1
- busy  output  1  1 while any source is granted
- an_out  output  8  to seven-segment driver anode input
- seg_out  output  56  to seven-segment driver segment input

Behaviour:
- Reset (reset=0, async): grant=0, owner=0, busy=0, an_out=8'h00, seg_out=56'h0, hold counter=0, last-owner pointer=NREQ-1 (source 0 wins first), state IDLE.
- States: IDLE, OWN, GAP.
- IDLE:
  - Any req bit set -> OWN next edge.
  - Winner is the first set bit searching upward from last+1, wrapping modulo NREQ.
  - grant/owner/busy update on that same edge; request-to-grant latency is 1 cycle.
- OWN:
  - an_out/seg_out register the owner's slice every cycle, so owner updates appear 1 cycle later.
  - Hold counter starts at 0 on entry and increments per cycle, saturating at HOLD_CYCLES.
  - Owner's req drops (any time, including before hold expiry) -> GAP.
  - Owner still requesting, another req set, counter == HOLD_CYCLES -> GAP.
  - Owner still requesting, no other req -> stay in OWN indefinitely.
  - Other requests arriving earlier than hold expiry are not granted; they wait.
- GAP (exactly 1 cycle):
  - Entry edge: grant=0, busy=0, an_out=0, seg_out=0, last pointer=old owner.
  - Display is blanked for one cycle to avoid mixed-digit glitches.
  - Next edge: behaves as IDLE, so a new winner is granted, or stay idle if req=0.
  - The previous owner can win again only if it is the sole requester.
- Non-owned sources' an_src/seg_src are ignored.
- Pattern width: seg_out digit k = seg_src[56i+7k+6 : 56i+7k]; passed through unmodified, no decoding.
- Simultaneous requests in IDLE: round-robin order above; no fixed priority (except under optional feature).
- Reset mid-grant: immediate return to reset values; pointer reset to NREQ-1.
- req bits for indexes >= NREQ do not exist; owner upper bits are 0 when NREQ<8.

Optional Feature:
- Macro: SEG_URGENT_PREEMPT_EN.
- Defined:
  - req[0] is urgent. If req[0]=1 while another source owns in OWN, go to GAP on the next edge regardless of hold count, then grant source 0.
  - Source 0 also wins in IDLE whenever it requests, overriding round-robin.
  - Source 0's own grant is never preempted.
- Undefined: source 0 is an ordinary round-robin requester; no preemption logic is synthesized.

Test Plan:
- NREQ=4, HOLD_CYCLES=4. Reset, then req=4'b0010 -> one cycle later grant=4'b0010, owner=1, busy=1; seg_src slice 1 = {P,ONE,0,ZERO pattern} appears on seg_out one cycle after grant.
- req=4'b0101 from IDLE after reset -> grant source 0. Keep both high: source 0 held exactly 4 cycles, 1 GAP cycle with seg_out=0/an_out=0, then grant=4'b0100.
- Owner 2, req[2] drops at hold count 1 with req[3]=1 -> GAP next edge, grant=4'b1000 the edge after; no wait for hold.
- Sole requester 1 held 100 cycles -> grant stays 4'b0010 throughout, no GAP cycles.
- Assert reset low mid-OWN (owner 3) -> outputs zero asynchronously. After release with req=4'b1001 -> source 0 granted first.
- With SEG_URGENT_PREEMPT_EN, owner 2 at hold count 1, raise req[0] -> GAP next edge, grant=4'b0001 following edge. Without macro, same stimulus -> owner 2 keeps grant until hold count 4.
